// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin writeback arbiter driving a registered register-file write port.
// Define REGWB_SCOREBOARD_EN to build the 32-entry pending-write scoreboard and read-hazard stalls.
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ack,
  input  logic        b_req,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ack,
  input  logic        hold,
  output logic        RegWEn,
  output logic [4:0]  AddrD,
  output logic [31:0] DataD,
  input  logic        sb_set,
  input  logic [4:0]  sb_addr,
  input  logic [4:0]  AddrA,
  input  logic [4:0]  AddrB,
  output logic        stall_a,
  output logic        stall_b
);

  logic        last_b_r;
  logic        grant_a_s;
  logic        grant_b_s;
  logic        grant_any_s;
  logic [4:0]  wr_addr_s;
  logic [31:0] wr_data_s;
  logic        wr_en_s;

  // Round-robin decision; reset and hold suppress every grant.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (!rst_n || hold) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else begin
      case ({a_req, b_req})
        2'b10: grant_a_s = 1'b1;
        2'b01: grant_b_s = 1'b1;
        2'b11: begin
          if (last_b_r) begin
            grant_a_s = 1'b1;
          end else begin
            grant_b_s = 1'b1;
          end
        end
        default: begin
          grant_a_s = 1'b0;
          grant_b_s = 1'b0;
        end
      endcase
    end
  end

  assign a_ack       = grant_a_s;
  assign b_ack       = grant_b_s;
  assign grant_any_s = grant_a_s | grant_b_s;

  // Select the winner's write payload; x0 is acked but never written.
  always_comb begin
    wr_addr_s = a_addr;
    wr_data_s = a_data;
    if (grant_b_s) begin
      wr_addr_s = b_addr;
      wr_data_s = b_data;
    end else begin
      wr_addr_s = a_addr;
      wr_data_s = a_data;
    end
    wr_en_s = grant_any_s && (wr_addr_s != 5'd0);
  end

  // Registered write port and last-granted pointer; pointer starts at B so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_b_r <= 1'b1;
      RegWEn   <= 1'b0;
      AddrD    <= 5'd0;
      DataD    <= 32'd0;
    end else begin
      RegWEn <= wr_en_s;
      if (grant_any_s) begin
        last_b_r <= grant_b_s;
        AddrD    <= wr_addr_s;
        DataD    <= wr_data_s;
      end
    end
  end

`ifdef REGWB_SCOREBOARD_EN
  logic [31:0] pending_r;
  logic [31:0] set_mask_s;
  logic [31:0] clr_mask_s;

  // A read sees a hazard only if pending and not covered by the write currently in flight.
  function automatic logic read_hazard(input logic [31:0] pend, input logic [4:0] raddr,
                                       input logic wen, input logic [4:0] waddr);
    read_hazard = pend[raddr] && (raddr != 5'd0) && !(wen && (waddr == raddr));
  endfunction

  // One-hot set/clear masks for this edge.
  always_comb begin
    set_mask_s = 32'd0;
    clr_mask_s = 32'd0;
    if (sb_set && (sb_addr != 5'd0)) begin
      set_mask_s[sb_addr] = 1'b1;
    end else begin
      set_mask_s = 32'd0;
    end
    if (RegWEn) begin
      clr_mask_s[AddrD] = 1'b1;
    end else begin
      clr_mask_s = 32'd0;
    end
  end

  // Set wins over a same-edge clear so a re-issued destination stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 32'd0;
    end else begin
      pending_r <= (pending_r & ~clr_mask_s) | set_mask_s;
    end
  end

  assign stall_a = read_hazard(pending_r, AddrA, RegWEn, AddrD);
  assign stall_b = read_hazard(pending_r, AddrB, RegWEn, AddrD);
`else
  logic sb_unused_s;
  assign sb_unused_s = ^{sb_set, sb_addr, AddrA, AddrB};
  assign stall_a     = 1'b0;
  assign stall_b     = 1'b0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL provide ports: clk input 1, the single clock; all state on its rising edge.
REQ-002 SHALL provide rst_n input 1; asynchronous, active-low reset.
REQ-003 SHALL provide a_req input 1, a_addr input 5, a_data input 32, a_ack output 1: ALU writeback requester.
REQ-004 SHALL provide b_req input 1, b_addr input 5, b_data input 32, b_ack output 1: load/multicycle writeback requester.
REQ-005 SHALL provide hold input 1: when high, blocks all grants.
REQ-006 SHALL provide RegWEn output 1, AddrD output 5, DataD output 32: the register-array write port, all registered.
REQ-007 SHALL provide sb_set input 1, sb_addr input 5: the issue stage marks a destination as pending.
REQ-008 SHALL provide AddrA input 5, AddrB input 5, stall_a output 1, stall_b output 1: read-hazard check.

Function
REQ-009 SHALL grant at most one requester per cycle; grant = req high, hold low, arbitration won.
REQ-010 SHALL assert x_ack combinationally in the grant cycle only; a requester holds req/addr/data stable until ack.
REQ-011 SHALL arbitrate round-robin: with both requesting, grant the one not granted most recently; a lone requester always wins.
REQ-012 SHALL update the last-granted pointer only on a grant; it is unchanged in idle or hold cycles.
REQ-013 SHALL, on the edge after a grant, load AddrD/DataD from the winner and set RegWEn=1 (1-cycle latency); else RegWEn=0.
REQ-014 SHALL ack a grant with addr 0 normally but keep RegWEn=0 on the next cycle (x0 unwritable); AddrD/DataD are still loaded.
REQ-015 SHALL hold AddrD/DataD at their last values when RegWEn=0.
REQ-016 SHALL sustain one write per cycle with back-to-back grants (A,B,A,B under continuous dual request).
REQ-017 SHALL force a_ack=b_ack=0 while hold=1; the pointer is frozen; the registered write of a grant made before hold still completes.

Reset
REQ-018 SHALL on rst_n low, immediately and independent of clk, set RegWEn=0, AddrD=0, DataD=0, pointer=B (so A wins first tie), pending mask=0.
REQ-019 SHALL drop any in-flight registered write on reset; no write is issued after reset release until a new grant.
REQ-020 SHALL keep a_ack/b_ack low while rst_n is low.

Configuration
REQ-021 SHALL compile a 32-bit pending scoreboard when macro REGWB_SCOREBOARD_EN is defined.
REQ-022 With REGWB_SCOREBOARD_EN: sb_set with sb_addr!=0 sets pending[sb_addr] at the edge; sb_addr=0 is ignored.
REQ-023 With REGWB_SCOREBOARD_EN: a cycle with RegWEn=1 clears pending[AddrD] at the edge; a same-edge set and clear of one address leaves it set.
REQ-024 With REGWB_SCOREBOARD_EN: stall_a = pending[AddrA] AND AddrA!=0 AND NOT(RegWEn AND AddrD==AddrA); stall_b likewise (the register array bypasses the write in flight).
REQ-025 Without REGWB_SCOREBOARD_EN: no mask storage; stall_a=stall_b=0 constantly; sb_set/sb_addr are ignored.

Verification
REQ-026 Reset: rst_n=0 mid-write (RegWEn=1, AddrD=5) -> RegWEn=0, AddrD=0, DataD=0 at once, without a clk edge.
REQ-027 Single request: a_req=1, a_addr=3, a_data=0xDEADBEEF -> a_ack=1 that cycle; next cycle RegWEn=1, AddrD=3, DataD=0xDEADBEEF.
REQ-028 Contention: a_req=b_req=1 held for 4 cycles from reset -> acks A,B,A,B; RegWEn=1 on 4 consecutive cycles, one cycle later.
REQ-029 x0 and hold: b_req=1 with b_addr=0 -> b_ack=1, next RegWEn=0; with hold=1 and a_req=1 for 3 cycles -> no ack; hold drop -> a_ack the same cycle.
REQ-030 Scoreboard (macro on): sb_set for addr 7, then AddrA=7 -> stall_a=1; grant writing 7 -> stall_a=0 in the RegWEn cycle and pending[7] cleared after; sb_set for 7 in that same cycle -> stall_a=1 again next cycle.
REQ-031 Scoreboard (macro off): the same stimulus as REQ-030 -> stall_a=stall_b=0 throughout.
